r16_n_skid_buf: RTL

R16_N_SKID_BUF -- requirements
Module: r16_n_skid_buf

---
 rtl/r16_n_skid_buf_pkg.sv | 14 +
 rtl/r16_n_en_reg.sv | 26 ++
 rtl/r16_n_skid_buf.sv | 127 ++++++++++++
 3 files changed

// File: rtl/r16_n_skid_buf_pkg.sv
// Shared definitions for the modulus-word skid buffer: default width, reset constant, FSM states.
package r16_n_skid_buf_pkg;

   localparam int unsigned P_WIDTH_DEF = 64;
   localparam logic [P_WIDTH_DEF-1:0] P_ZERO = '0;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

endpackage

// File: rtl/r16_n_en_reg.sv
// Enable-loaded data register, asynchronously cleared to P_ZERO.
module r16_n_en_reg
   import r16_n_skid_buf_pkg::*;
#(
   parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic [P_WIDTH-1:0] d_i,
   output logic [P_WIDTH-1:0] q_o
);

   logic [P_WIDTH-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= P_WIDTH'(P_ZERO);
      end else if (en_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/r16_n_skid_buf.sv
// Two-entry skid buffer for the modulus word N; all outputs registered, ready is
// independent of the downstream ready.
module r16_n_skid_buf
   import r16_n_skid_buf_pkg::*;
#(
   parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [P_WIDTH-1:0] N_in,
   input  logic               N_in_valid,
   output logic               N_in_ready,
   output logic [P_WIDTH-1:0] N_out,
   output logic               N_out_valid,
   input  logic               N_out_ready,
   output logic               N_out_chg,
   output logic [1:0]         N_cnt
);

   state_e             state_q, state_d;
   logic               push, pop, chg_in;
   logic               main_en, skid_en;
   logic [P_WIDTH-1:0] main_d, main_q, skid_q;
   logic               main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic               main_chg_q, main_chg_d, skid_chg_q, skid_chg_d;
   logic               rdy_en_q;
   logic               last_vld_q;
   logic [P_WIDTH-1:0] last_q;

   assign N_in_ready = rdy_en_q & ~skid_vld_q;
   assign push       = N_in_valid & N_in_ready;
   assign pop        = main_vld_q & N_out_ready;
   // last_vld_q forces chg on the first word after reset, even if that word is zero.
   assign chg_in     = ~last_vld_q | (N_in != last_q);

   always_comb begin
      state_d    = state_q;
      main_en    = 1'b0;
      main_d     = N_in;
      skid_en    = 1'b0;
      main_chg_d = main_chg_q;
      skid_chg_d = skid_chg_q;
      case (state_q)
         StEmpty: begin
            if (push) begin
               state_d    = StOne;
               main_en    = 1'b1;
               main_chg_d = chg_in;
            end
         end
         StOne: begin
            if (push && pop) begin
               main_en    = 1'b1;
               main_chg_d = chg_in;
            end else if (push) begin
               state_d    = StFull;
               skid_en    = 1'b1;
               skid_chg_d = chg_in;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) begin
               state_d    = StOne;
               main_en    = 1'b1;
               main_d     = skid_q;
               main_chg_d = skid_chg_q;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   assign main_vld_d = (state_d != StEmpty);
   assign skid_vld_d = (state_d == StFull);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StEmpty;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_chg_q <= 1'b0;
         skid_chg_q <= 1'b0;
         rdy_en_q   <= 1'b0;
         last_vld_q <= 1'b0;
         last_q     <= P_WIDTH'(P_ZERO);
      end else begin
         state_q    <= state_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_chg_q <= main_chg_d;
         skid_chg_q <= skid_chg_d;
         rdy_en_q   <= 1'b1;
         if (push) begin
            last_vld_q <= 1'b1;
            last_q     <= N_in;
         end
      end
   end

   r16_n_en_reg #(
      .P_WIDTH (P_WIDTH)
   ) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (main_en),
      .d_i   (main_d),
      .q_o   (main_q)
   );

   r16_n_en_reg #(
      .P_WIDTH (P_WIDTH)
   ) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (skid_en),
      .d_i   (N_in),
      .q_o   (skid_q)
   );

   assign N_out       = main_q;
   assign N_out_valid = main_vld_q;
   assign N_out_chg   = main_chg_q;
   assign N_cnt       = state_q;

endmodule
